axi4_lite_mem_slave: RTL and testbench
======================================

Name: axi4_lite_mem_slave

Overview:
- AXI4-Lite slave that terminates the bus driven by the SoC's AXI4-Lite master.
- Fronts a word-organised, byte-enabled synchronous RAM that serves as data memory / scratchpad.
- Independent write path (AW/W/B) and read path (AR/R) with registered handshakes.
- Out-of-range accesses return SLVERR and never corrupt memory.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width; fixed at 32 (4 strobe bits).
- BASE_ADDR, 32'h0000_1000, byte address of word 0.
- MEM_DEPTH, 1024, number of 32-bit words; power of two, at least 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- S_AXI_AWADDR  in  ADDR_WIDTH  write address
- S_AXI_AWVALID  in  1  write address valid
- S_AXI_AWREADY  out  1  slave can accept write address
- S_AXI_WDATA  in  DATA_WIDTH  write data
- S_AXI_WSTRB  in  4  byte enables; bit i enables byte i
- S_AXI_WVALID  in  1  write data valid
- S_AXI_WREADY  out  1  slave can accept write data
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID  out  1  write response valid
- S_AXI_BREADY  in  1  master accepts response
- S_AXI_ARADDR  in  ADDR_WIDTH  read address
- S_AXI_ARVALID  in  1  read address valid
- S_AXI_ARREADY  out  1  slave can accept read address
- S_AXI_RDATA  out  DATA_WIDTH  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID  out  1  read data valid
- S_AXI_RREADY  in  1  master accepts read data

Behaviour:
Reset
- Async assert, sync release.
- AWREADY, WREADY, ARREADY reset to 1.
- BVALID, RVALID reset to 0; BRESP, RRESP, RDATA reset to 0.
- Memory contents are not reset.
- Reset mid-transaction drops all latched AW/W/AR state; an uncommitted write is never performed.

Decode
- in_range = (addr >= BASE_ADDR) && (addr < BASE_ADDR + 4*MEM_DEPTH).
- Word index = (addr - BASE_ADDR) >> 2, truncated to clog2(MEM_DEPTH) bits.
- addr[1:0] is ignored.

Write FSM (W_IDLE, W_RESP)
- AW and W handshakes are accepted independently and in either order.
- Each accepted channel latches its payload into a holding register and drops its READY the next cycle.
- Commit happens on the clock edge at which the second of the two handshakes completes; live values are used for whichever channel handshakes that cycle.
- Simultaneous AW+W handshake commits on that same edge.
- Commit, in range: bytes with WSTRB=1 are written and the rest are preserved; BRESP=OKAY.
- Commit, out of range: no memory write; BRESP=SLVERR.
- WSTRB=0 in range: no bytes change; BRESP=OKAY.
- BVALID rises the cycle after commit; BVALID and BRESP stay stable until BREADY.
- On the B handshake edge: BVALID goes to 0, AWREADY and WREADY go to 1 (state returns to W_IDLE).
- While in W_RESP, AWREADY and WREADY are 0.

Read FSM (R_IDLE, R_DATA)
- On AR handshake at edge N: RAM is read synchronously, RDATA/RRESP are registered, and RVALID=1 in cycle N+1.
- ARREADY is 0 while RVALID=1.
- Out of range: RDATA=0, RRESP=SLVERR.
- RDATA and RRESP are held stable until RREADY.
- On the R handshake edge: RVALID goes to 0 and ARREADY goes to 1.

Concurrency
- Read and write paths are fully independent.
- A read sampling the same word on the same edge as a write commit returns the old data (read-before-write).

Decomposition:
- axi4_lite_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, STRB_WIDTH=4, and a typedef for the 2-bit response.
- Sub-module axi4_lite_mem_bank: MEM_DEPTH x 32 synchronous RAM with one byte-enabled write port and one registered read port.
- Handshake/FSM logic stays in axi4_lite_mem_slave.

Test Plan:
1. AW=0x1004 and W=0xDEADBEEF (WSTRB=4'hF) in the same cycle, BREADY=1 -> BVALID 1 cycle later, BRESP=00; a subsequent read of 0x1004 returns 0xDEADBEEF with RVALID 1 cycle after ARREADY&ARVALID.
2. W (0x000000AA, WSTRB=4'b0001) 3 cycles before AW=0x1004 -> commit on the AW edge; read of 0x1004 returns 0xDEADBEAA; WREADY stays 0 in between.
3. Write 0x2000 (just past the end) and read 0x0FFC -> BRESP=10 and RRESP=10 with RDATA=0; memory at 0x1FFC is unchanged.
4. Backpressure: BREADY=0 and RREADY=0 for 5 cycles -> BVALID/BRESP and RVALID/RDATA stay stable; AWREADY, WREADY and ARREADY stay 0 until the handshake, then return to 1 the next cycle.
5. Same-edge read and write commit to 0x1010 (old 0x11111111, new 0x22222222) -> read returns 0x11111111; the next read returns 0x22222222.
6. Assert rst after the AW handshake but before W -> all VALIDs go to 0 and READYs go to 1 immediately; a later read shows the target word unchanged.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite response codes, strobe width and FSM state types
// for the memory-mapped scratchpad slave.
package axi4_lite_pkg;

    localparam int STRB_WIDTH = 4;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

endpackage

// File: rtl/axi4_lite_mem_slave_if.sv
// AXI4-Lite bus bundle between the SoC master and the scratchpad slave.
interface axi4_lite_mem_slave_if
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] S_AXI_AWADDR;
    logic                  S_AXI_AWVALID;
    logic                  S_AXI_AWREADY;
    logic [DATA_WIDTH-1:0] S_AXI_WDATA;
    logic [STRB_WIDTH-1:0] S_AXI_WSTRB;
    logic                  S_AXI_WVALID;
    logic                  S_AXI_WREADY;
    resp_t                 S_AXI_BRESP;
    logic                  S_AXI_BVALID;
    logic                  S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
    logic                  S_AXI_ARVALID;
    logic                  S_AXI_ARREADY;
    logic [DATA_WIDTH-1:0] S_AXI_RDATA;
    resp_t                 S_AXI_RRESP;
    logic                  S_AXI_RVALID;
    logic                  S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

endinterface

// File: rtl/axi4_lite_mem_bank.sv
// Word-organised scratchpad RAM: one byte-enabled write port and one
// registered read port. A read and write to the same word on the same
// edge returns the old contents.
module axi4_lite_mem_bank
    import axi4_lite_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [31:0]           wr_data,
    input  logic [STRB_WIDTH-1:0] wr_strb,
    input  logic                  rd_en,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [31:0]           rd_data
);

    logic [31:0] mem [MEM_DEPTH];
    logic [31:0] rd_data_q;

    // Byte-lane write: only lanes with their strobe set are updated.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Read register only loads on a new request so data holds while stalled.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= mem[rd_idx];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/axi4_lite_mem_slave.sv
// AXI4-Lite slave fronting the scratchpad RAM. Write and read paths are
// independent FSMs; out-of-range accesses answer SLVERR and never touch
// the memory.
module axi4_lite_mem_slave
    import axi4_lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_1000,
    parameter int                    MEM_DEPTH  = 1024
) (
    input logic                  clk,
    input logic                  rst,
    axi4_lite_mem_slave_if.slave s_axi
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] BASE_EXT  = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] LIMIT_EXT = BASE_EXT + (ADDR_WIDTH+1)'(4 * MEM_DEPTH);

    // Compare in one extra bit so a window ending at the top of the
    // address space does not wrap.
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH:0] addr_ext;
        addr_ext = {1'b0, addr};
        return (addr_ext >= BASE_EXT) && (addr_ext < LIMIT_EXT);
    endfunction

    function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> 2);
    endfunction

    // ---------------- write path ----------------
    wr_state_t             w_state_q, w_state_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    resp_t                 bresp_q, bresp_d;

    logic                  aw_hs, w_hs;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] commit_addr;
    logic [DATA_WIDTH-1:0] commit_data;
    logic [STRB_WIDTH-1:0] commit_strb;

    // Write state register; reset discards any half-collected AW/W pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
        end
    end

    // Write next-state: latch each channel, commit once both have arrived.
    always_comb begin
        w_state_d   = w_state_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        bresp_d     = bresp_q;
        mem_we      = 1'b0;
        commit_addr = aw_hs ? s_axi.S_AXI_AWADDR : awaddr_q;
        commit_data = w_hs  ? s_axi.S_AXI_WDATA  : wdata_q;
        commit_strb = w_hs  ? s_axi.S_AXI_WSTRB  : wstrb_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_done_d = 1'b1;
                    awaddr_d  = s_axi.S_AXI_AWADDR;
                end
                if (w_hs) begin
                    w_done_d = 1'b1;
                    wdata_d  = s_axi.S_AXI_WDATA;
                    wstrb_d  = s_axi.S_AXI_WSTRB;
                end
                if ((aw_hs || aw_done_q) && (w_hs || w_done_q)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    w_state_d = W_RESP;
                    if (addr_in_range(commit_addr)) begin
                        mem_we  = 1'b1;
                        bresp_d = RESP_OKAY;
                    end else begin
                        bresp_d = RESP_SLVERR;
                    end
                end
            end
            W_RESP: begin
                if (s_axi.S_AXI_BREADY) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write outputs: a channel stays ready until its payload is held.
    always_comb begin
        s_axi.S_AXI_AWREADY = (w_state_q == W_IDLE) && !aw_done_q;
        s_axi.S_AXI_WREADY  = (w_state_q == W_IDLE) && !w_done_q;
        s_axi.S_AXI_BVALID  = (w_state_q == W_RESP);
        s_axi.S_AXI_BRESP   = bresp_q;
        aw_hs = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
        w_hs  = s_axi.S_AXI_WVALID  && s_axi.S_AXI_WREADY;
    end

    // ---------------- read path ----------------
    rd_state_t   r_state_q, r_state_d;
    resp_t       rresp_q, rresp_d;
    logic        rsel_q, rsel_d;
    logic        ar_hs;
    logic        rd_en;
    logic [31:0] bank_rdata;

    // Read state register; rsel_q marks that the bank holds valid read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            rresp_q   <= RESP_OKAY;
            rsel_q    <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            rresp_q   <= rresp_d;
            rsel_q    <= rsel_d;
        end
    end

    // Read next-state: capture the response on AR, release on R handshake.
    always_comb begin
        r_state_d = r_state_q;
        rresp_d   = rresp_q;
        rsel_d    = rsel_q;
        rd_en     = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d = R_DATA;
                    if (addr_in_range(s_axi.S_AXI_ARADDR)) begin
                        rd_en   = 1'b1;
                        rsel_d  = 1'b1;
                        rresp_d = RESP_OKAY;
                    end else begin
                        rsel_d  = 1'b0;
                        rresp_d = RESP_SLVERR;
                    end
                end
            end
            R_DATA: begin
                if (s_axi.S_AXI_RREADY) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read outputs: data is forced to zero for errors and out of reset.
    always_comb begin
        s_axi.S_AXI_ARREADY = (r_state_q == R_IDLE);
        s_axi.S_AXI_RVALID  = (r_state_q == R_DATA);
        s_axi.S_AXI_RRESP   = rresp_q;
        s_axi.S_AXI_RDATA   = rsel_q ? DATA_WIDTH'(bank_rdata) : '0;
        ar_hs = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
    end

    axi4_lite_mem_bank #(
        .MEM_DEPTH (MEM_DEPTH),
        .IDX_W     (IDX_W)
    ) u_bank (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_idx  (word_index(commit_addr)),
        .wr_data (32'(commit_data)),
        .wr_strb (commit_strb),
        .rd_en   (rd_en),
        .rd_idx  (word_index(s_axi.S_AXI_ARADDR)),
        .rd_data (bank_rdata)
    );

endmodule

// File: tb/tb_axi4_lite_mem_slave.sv
// Directed testbench for the AXI4-Lite scratchpad slave.
module tb_axi4_lite_mem_slave;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    axi4_lite_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi4_lite_mem_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .BASE_ADDR  (32'h0000_1000),
        .MEM_DEPTH  (1024)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .s_axi (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
        bit aw_pend, w_pend, aw_go, w_go;
        int cyc;
        aw_pend = 1'b1;
        w_pend  = 1'b1;
        bus.S_AXI_AWADDR  = addr;
        bus.S_AXI_WDATA   = data;
        bus.S_AXI_WSTRB   = strb;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        cyc = 0;
        while ((aw_pend || w_pend) && cyc < 20) begin
            aw_go = aw_pend && bus.S_AXI_AWREADY;
            w_go  = w_pend && bus.S_AXI_WREADY;
            step();
            if (aw_go) begin bus.S_AXI_AWVALID = 1'b0; aw_pend = 1'b0; end
            if (w_go)  begin bus.S_AXI_WVALID  = 1'b0; w_pend  = 1'b0; end
            cyc++;
        end
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        cyc = 0;
        while (!bus.S_AXI_BVALID && cyc < 20) begin
            step();
            cyc++;
        end
        checks++;
        if (bus.S_AXI_BVALID !== 1'b1) begin
            errors++;
            $display("[TB] FAIL write_timeout addr=%h bvalid=%b expected 1", addr, bus.S_AXI_BVALID);
            resp = 2'bxx;
        end else begin
            resp = bus.S_AXI_BRESP;
            bus.S_AXI_BREADY = 1'b1;
            step();
            bus.S_AXI_BREADY = 1'b0;
        end
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit ar_go;
        int cyc;
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARVALID = 1'b1;
        cyc = 0;
        ar_go = 1'b0;
        while (!ar_go && cyc < 20) begin
            ar_go = bus.S_AXI_ARREADY;
            step();
            cyc++;
        end
        bus.S_AXI_ARVALID = 1'b0;
        cyc = 0;
        while (!bus.S_AXI_RVALID && cyc < 20) begin
            step();
            cyc++;
        end
        checks++;
        if (bus.S_AXI_RVALID !== 1'b1) begin
            errors++;
            $display("[TB] FAIL read_timeout addr=%h rvalid=%b expected 1", addr, bus.S_AXI_RVALID);
            data = 'x;
            resp = 2'bxx;
        end else begin
            data = bus.S_AXI_RDATA;
            resp = bus.S_AXI_RRESP;
            bus.S_AXI_RREADY = 1'b1;
            step();
            bus.S_AXI_RREADY = 1'b0;
        end
    endtask

    task automatic test_reset();
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID} !== 5'b11100) begin
            errors++;
            $display("[TB] FAIL reset_handshake got %b expected 11100",
                     {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID});
        end
        checks++;
        if ({bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA} !== 36'h0) begin
            errors++;
            $display("[TB] FAIL reset_payload got bresp=%b rresp=%b rdata=%h expected zeros",
                     bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();
    endtask

    task automatic test_simultaneous_write();
        bus.S_AXI_AWADDR = 32'h1004; bus.S_AXI_WDATA = 32'hDEADBEEF; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_BREADY = 1'b1;
        step();
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        checks++;
        if ({bus.S_AXI_BVALID, bus.S_AXI_BRESP, bus.S_AXI_AWREADY, bus.S_AXI_WREADY} !== 5'b10000) begin
            errors++;
            $display("[TB] FAIL t1_bresp got bvalid=%b bresp=%b awready=%b wready=%b expected 1 00 0 0",
                     bus.S_AXI_BVALID, bus.S_AXI_BRESP, bus.S_AXI_AWREADY, bus.S_AXI_WREADY);
        end
        step();
        bus.S_AXI_BREADY = 1'b0;
        checks++;
        if ({bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL t1_b_done got bvalid/awready/wready=%b expected 011",
                     {bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY});
        end
        bus.S_AXI_ARADDR = 32'h1004; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b0;
        step();
        bus.S_AXI_ARVALID = 1'b0;
        checks++;
        if ({bus.S_AXI_RVALID, bus.S_AXI_ARREADY, bus.S_AXI_RRESP, bus.S_AXI_RDATA} !== {1'b1, 1'b0, 2'b00, 32'hDEADBEEF}) begin
            errors++;
            $display("[TB] FAIL t1_read got rvalid=%b arready=%b rresp=%b rdata=%h expected 1 0 00 deadbeef",
                     bus.S_AXI_RVALID, bus.S_AXI_ARREADY, bus.S_AXI_RRESP, bus.S_AXI_RDATA);
        end
        bus.S_AXI_RREADY = 1'b1;
        step();
        bus.S_AXI_RREADY = 1'b0;
        checks++;
        if ({bus.S_AXI_RVALID, bus.S_AXI_ARREADY} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL t1_r_done got rvalid/arready=%b expected 01", {bus.S_AXI_RVALID, bus.S_AXI_ARREADY});
        end
    endtask

    task automatic test_w_before_aw();
        logic [31:0] data;
        logic [1:0]  resp;
        bus.S_AXI_WDATA = 32'h0000_00AA; bus.S_AXI_WSTRB = 4'b0001; bus.S_AXI_WVALID = 1'b1;
        step();
        bus.S_AXI_WVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({bus.S_AXI_WREADY, bus.S_AXI_BVALID, bus.S_AXI_AWREADY} !== 3'b001) begin
                errors++;
                $display("[TB] FAIL t2_wait%0d got wready/bvalid/awready=%b expected 001", i,
                         {bus.S_AXI_WREADY, bus.S_AXI_BVALID, bus.S_AXI_AWREADY});
            end
            if (i < 2) step();
        end
        bus.S_AXI_AWADDR = 32'h1004; bus.S_AXI_AWVALID = 1'b1;
        step();
        bus.S_AXI_AWVALID = 1'b0;
        checks++;
        if ({bus.S_AXI_BVALID, bus.S_AXI_BRESP} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL t2_commit got bvalid=%b bresp=%b expected 1 00", bus.S_AXI_BVALID, bus.S_AXI_BRESP);
        end
        bus.S_AXI_BREADY = 1'b1;
        step();
        bus.S_AXI_BREADY = 1'b0;
        do_read(32'h1004, data, resp);
        checks++;
        if (data !== 32'hDEADBEAA || resp !== 2'b00) begin
            errors++;
            $display("[TB] FAIL t2_read got %h/%b expected deadbeaa/00", data, resp);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] data;
        logic [1:0]  resp;
        do_write(32'h1000, 32'h0102_0304, 4'hF, resp);
        do_write(32'h1FFC, 32'hCAFE_F00D, 4'hF, resp);
        checks++;
        if (resp !== 2'b00) begin errors++; $display("[TB] FAIL t3_last_word_bresp got %b expected 00", resp); end
        do_write(32'h2000, 32'h1234_5678, 4'hF, resp);
        checks++;
        if (resp !== 2'b10) begin errors++; $display("[TB] FAIL t3_past_end_bresp got %b expected 10", resp); end
        do_read(32'h0FFC, data, resp);
        checks++;
        if (data !== 32'h0 || resp !== 2'b10) begin
            errors++;
            $display("[TB] FAIL t3_below_base_read got %h/%b expected 00000000/10", data, resp);
        end
        do_read(32'h2000, data, resp);
        checks++;
        if (data !== 32'h0 || resp !== 2'b10) begin
            errors++;
            $display("[TB] FAIL t3_past_end_read got %h/%b expected 00000000/10", data, resp);
        end
        do_read(32'h1FFF, data, resp);
        checks++;
        if (data !== 32'hCAFEF00D || resp !== 2'b00) begin
            errors++;
            $display("[TB] FAIL t3_last_word_read got %h/%b expected cafef00d/00", data, resp);
        end
        do_read(32'h1000, data, resp);
        checks++;
        if (data !== 32'h01020304) begin
            errors++;
            $display("[TB] FAIL t3_word0_intact got %h expected 01020304", data);
        end
        do_write(32'h1000, 32'hFFFF_FFFF, 4'h0, resp);
        checks++;
        if (resp !== 2'b00) begin errors++; $display("[TB] FAIL t3_nostrb_bresp got %b expected 00", resp); end
        do_read(32'h1000, data, resp);
        checks++;
        if (data !== 32'h01020304) begin
            errors++;
            $display("[TB] FAIL t3_nostrb_read got %h expected 01020304", data);
        end
        do_write(32'h1000, 32'hAABB_CCDD, 4'b1010, resp);
        do_read(32'h1000, data, resp);
        checks++;
        if (data !== 32'hAA02CC04) begin
            errors++;
            $display("[TB] FAIL t3_partial_strb got %h expected aa02cc04", data);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] data;
        logic [1:0]  resp;
        bus.S_AXI_AWADDR = 32'h1008; bus.S_AXI_WDATA = 32'h55AA_55AA; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_ARADDR = 32'h1004;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
        bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
        step();
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus.S_AXI_BVALID, bus.S_AXI_BRESP, bus.S_AXI_RVALID, bus.S_AXI_RRESP, bus.S_AXI_RDATA,
                 bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}
                    !== {1'b1, 2'b00, 1'b1, 2'b00, 32'hDEADBEAA, 3'b000}) begin
                errors++;
                $display("[TB] FAIL t4_stall%0d got bvalid=%b bresp=%b rvalid=%b rresp=%b rdata=%h readys=%b expected 1 00 1 00 deadbeaa 000",
                         i, bus.S_AXI_BVALID, bus.S_AXI_BRESP, bus.S_AXI_RVALID, bus.S_AXI_RRESP, bus.S_AXI_RDATA,
                         {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY});
            end
            step();
        end
        bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
        step();
        bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
        checks++;
        if ({bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 5'b00111) begin
            errors++;
            $display("[TB] FAIL t4_release got %b expected 00111",
                     {bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY});
        end
        do_read(32'h1008, data, resp);
        checks++;
        if (data !== 32'h55AA55AA) begin errors++; $display("[TB] FAIL t4_write_landed got %h expected 55aa55aa", data); end
    endtask

    task automatic test_read_during_write();
        logic [31:0] data;
        logic [1:0]  resp;
        do_write(32'h1010, 32'h1111_1111, 4'hF, resp);
        bus.S_AXI_AWADDR = 32'h1010; bus.S_AXI_WDATA = 32'h2222_2222; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_ARADDR = 32'h1010;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
        step();
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
        checks++;
        if ({bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_RDATA} !== {2'b11, 32'h11111111}) begin
            errors++;
            $display("[TB] FAIL t5_old_data got bvalid=%b rvalid=%b rdata=%h expected 1 1 11111111",
                     bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_RDATA);
        end
        bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
        step();
        bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
        do_read(32'h1010, data, resp);
        checks++;
        if (data !== 32'h22222222) begin errors++; $display("[TB] FAIL t5_new_data got %h expected 22222222", data); end
    endtask

    task automatic test_reset_mid_transaction();
        logic [31:0] data;
        logic [1:0]  resp;
        do_write(32'h1018, 32'h0BAD_F00D, 4'hF, resp);
        bus.S_AXI_AWADDR = 32'h1018; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'hFFFF_FFFF; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_ARADDR = 32'h1018; bus.S_AXI_ARVALID = 1'b1;
        step();
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
        checks++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_RVALID} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL t6_pre_reset got awready/wready/rvalid=%b expected 011",
                     {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_RVALID});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID,
             bus.S_AXI_RDATA, bus.S_AXI_RRESP} !== {5'b11100, 32'h0, 2'b00}) begin
            errors++;
            $display("[TB] FAIL t6_async_reset got hs=%b rdata=%h rresp=%b expected 11100 00000000 00",
                     {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID},
                     bus.S_AXI_RDATA, bus.S_AXI_RRESP);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        do_write(32'h101C, 32'h7777_7777, 4'hF, resp);
        do_read(32'h1018, data, resp);
        checks++;
        if (data !== 32'h0BADF00D) begin errors++; $display("[TB] FAIL t6_target_intact got %h expected 0badf00d", data); end
        do_read(32'h101C, data, resp);
        checks++;
        if (data !== 32'h77777777) begin errors++; $display("[TB] FAIL t6_post_reset_write got %h expected 77777777", data); end
    endtask

    initial begin
        test_reset();
        test_simultaneous_write();
        test_w_before_aw();
        test_out_of_range();
        test_backpressure();
        test_read_during_write();
        test_reset_mid_transaction();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
